// File: rtl/msrv_32_pkg.sv
// Shared encodings for the data-memory access unit: access sizes, FSM
// states, byte-lane mask constants and the misalignment rule.
package msrv_32_pkg;

    // Access size encoding on load_size_in (bit 1 set means word).
    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;

    // Request-tracking FSM states.
    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // Byte-lane write masks.
    localparam logic [3:0] MASK_NONE    = 4'b0000;
    localparam logic [3:0] MASK_BYTE0   = 4'b0001;
    localparam logic [3:0] MASK_HALF_LO = 4'b0011;
    localparam logic [3:0] MASK_HALF_HI = 4'b1100;
    localparam logic [3:0] MASK_WORD    = 4'b1111;

    // A half must sit on an even address, a word on a multiple of four.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (size[1]) begin
            mis = (addr_lo != 2'b00);
        end else if (size == LS_HALF) begin
            mis = addr_lo[0];
        end
        return mis;
    endfunction

endpackage

// File: rtl/msrv_32_store_lane_steer.sv
// Combinational store steering: replicates right-aligned store data onto
// every lane it could land in and selects the byte-lane mask from the
// access size and the low address bits.
module msrv_32_store_lane_steer
    import msrv_32_pkg::*;
(
    input  logic [1:0]  size_in,
    input  logic [1:0]  addr_lo_in,
    input  logic [31:0] rs2_in,
    output logic [31:0] data_out,
    output logic [3:0]  mask_out
);

    // Pick data replication and lane mask for the access size.
    always_comb begin
        // NOTE: every output gets a default before the branches so no path
        // leaves it unassigned, which would otherwise infer a latch.
        data_out = rs2_in;
        mask_out = MASK_WORD;
        if (size_in[1]) begin
            data_out = rs2_in;
            mask_out = MASK_WORD;
        end else if (size_in == LS_HALF) begin
            data_out = {2{rs2_in[15:0]}};
            mask_out = addr_lo_in[1] ? MASK_HALF_HI : MASK_HALF_LO;
        end else begin
            data_out = {4{rs2_in[7:0]}};
            mask_out = MASK_BYTE0 << addr_lo_in;
        end
    end

endmodule

// File: rtl/msrv_32_dmem_access_unit.sv
// Data-memory access controller. Registers one load/store per request,
// drives the word-aligned bus address, steered write data and byte mask,
// holds the request until ahb_ready_in or the watchdog fires, then pulses
// done_out and captures load results for the load unit.
// Optional feature macro: MSRV32_MISALIGN_DETECT_EN (misaligned halves and
// words complete without a bus request and report misaligned_out).
module msrv_32_dmem_access_unit
    import msrv_32_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        mem_valid_in,
    input  logic        mem_is_store_in,
    input  logic [31:0] iadder_in,
    input  logic [31:0] rs2_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    input  logic        ahb_ready_in,
    input  logic        ahb_resp_in,
    input  logic [31:0] ms_riscv32_mp_dmdata_in,
    output logic [31:0] ms_riscv32_mp_dmaddr_out,
    output logic [31:0] ms_riscv32_mp_dmdata_out,
    output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
    output logic        ms_riscv32_mp_dmwr_req_out,
    output logic        ms_riscv32_mp_dmrd_req_out,
    output logic        stall_out,
    output logic        done_out,
    output logic        err_out,
    output logic        misaligned_out,
    output logic [31:0] lu_dmdata_out,
    output logic [1:0]  lu_iadder_1_to_0_out,
    output logic [1:0]  lu_load_size_out,
    output logic        lu_load_unsigned_out,
    output logic        lu_resp_out
);

    // Counter only needs to reach TIMEOUT_CYCLES-1; it saturates at all-ones.
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic        is_store_q, is_store_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        uns_q, uns_d;
    logic        misal_q, misal_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        misal_out_q, misal_out_d;
    logic [31:0] lu_data_q, lu_data_d;
    logic [1:0]  lu_lo_q, lu_lo_d;
    logic [1:0]  lu_size_q, lu_size_d;
    logic        lu_uns_q, lu_uns_d;
    logic        lu_resp_q, lu_resp_d;

    logic [31:0] steer_data;
    logic [3:0]  steer_mask;
    logic        accept;
    logic        timeout_hit;
    logic        exit_req;
    logic        misal_acc;
    logic        err_now;

    msrv_32_store_lane_steer u_steer (
        .size_in    (load_size_in),
        .addr_lo_in (iadder_in[1:0]),
        .rs2_in     (rs2_in),
        .data_out   (steer_data),
        .mask_out   (steer_mask)
    );

`ifdef MSRV32_MISALIGN_DETECT_EN
    assign misal_acc = is_misaligned(load_size_in, iadder_in[1:0]);
`else
    assign misal_acc = 1'b0;
`endif

    assign accept      = (state_q == IDLE) && mem_valid_in;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
    assign exit_req    = (state_q == REQ) && (misal_q || ahb_ready_in || timeout_hit);
    // A completed transfer reports the bus response; an abort is always an error.
    assign err_now     = ahb_ready_in ? ahb_resp_in : 1'b1;

    // FSM state register.
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (ms_riscv32_mp_rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: open on a request, close on ready, timeout or misalignment.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem_valid_in) state_d = REQ;
            REQ:     if (exit_req)     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: stall and bus requests follow the open request.
    always_comb begin
        stall_out                  = (state_q == REQ);
        ms_riscv32_mp_dmrd_req_out = (state_q == REQ) && !is_store_q && !misal_q;
        ms_riscv32_mp_dmwr_req_out = (state_q == REQ) &&  is_store_q && !misal_q;
    end

    // Datapath next values: capture on accept, count while waiting, report on exit.
    always_comb begin
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        is_store_d  = is_store_q;
        size_d      = size_q;
        addr_lo_d   = addr_lo_q;
        uns_d       = uns_q;
        misal_d     = misal_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        misal_out_d = 1'b0;
        lu_data_d   = lu_data_q;
        lu_lo_d     = lu_lo_q;
        lu_size_d   = lu_size_q;
        lu_uns_d    = lu_uns_q;
        lu_resp_d   = lu_resp_q;

        if (accept) begin
            cnt_d      = '0;
            addr_d     = {iadder_in[31:2], 2'b00};
            wdata_d    = mem_is_store_in ? steer_data : '0;
            mask_d     = (mem_is_store_in && !misal_acc) ? steer_mask : MASK_NONE;
            is_store_d = mem_is_store_in;
            size_d     = load_size_in;
            addr_lo_d  = iadder_in[1:0];
            uns_d      = load_unsigned_in;
            misal_d    = misal_acc;
        end

        if (state_q == REQ) begin
            if (!ahb_ready_in && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (exit_req) begin
                done_d = 1'b1;
                if (misal_q) begin
                    misal_out_d = 1'b1;
                end else begin
                    err_d = err_now;
                    if (!is_store_q) begin
                        lu_data_d = err_now ? 32'h0 : ms_riscv32_mp_dmdata_in;
                        lu_resp_d = err_now;
                        lu_lo_d   = addr_lo_q;
                        lu_size_d = size_q;
                        lu_uns_d  = uns_q;
                    end
                end
            end
        end
    end

    // Datapath registers; everything clears on reset so outputs start at 0.
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            is_store_q  <= 1'b0;
            size_q      <= '0;
            addr_lo_q   <= '0;
            uns_q       <= 1'b0;
            misal_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            misal_out_q <= 1'b0;
            lu_data_q   <= '0;
            lu_lo_q     <= '0;
            lu_size_q   <= '0;
            lu_uns_q    <= 1'b0;
            lu_resp_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            is_store_q  <= is_store_d;
            size_q      <= size_d;
            addr_lo_q   <= addr_lo_d;
            uns_q       <= uns_d;
            misal_q     <= misal_d;
            done_q      <= done_d;
            err_q       <= err_d;
            misal_out_q <= misal_out_d;
            lu_data_q   <= lu_data_d;
            lu_lo_q     <= lu_lo_d;
            lu_size_q   <= lu_size_d;
            lu_uns_q    <= lu_uns_d;
            lu_resp_q   <= lu_resp_d;
        end
    end

    assign ms_riscv32_mp_dmaddr_out    = addr_q;
    assign ms_riscv32_mp_dmdata_out    = wdata_q;
    assign ms_riscv32_mp_dmwr_mask_out = mask_q;
    assign done_out                    = done_q;
    assign err_out                     = err_q;
    assign misaligned_out              = misal_out_q;
    assign lu_dmdata_out               = lu_data_q;
    assign lu_iadder_1_to_0_out        = lu_lo_q;
    assign lu_load_size_out            = lu_size_q;
    assign lu_load_unsigned_out        = lu_uns_q;
    assign lu_resp_out                 = lu_resp_q;

endmodule

// File: tb/tb_msrv_32_dmem_access_unit.sv
// Self-checking bench for msrv_32_dmem_access_unit: directed scenarios
// followed by random loads/stores checked against a transaction-level model.
module tb_msrv_32_dmem_access_unit;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_is_store, load_unsigned, ahb_ready, ahb_resp;
    logic [31:0] iadder, rs2, dmdata_in;
    logic [1:0]  load_size;
    logic [31:0] dmaddr, dmdata_out, lu_dmdata;
    logic [3:0]  wr_mask;
    logic        wr_req, rd_req, stall, done, err, misaligned;
    logic [1:0]  lu_lo, lu_size;
    logic        lu_uns, lu_resp;

    int checks   = 0;
    int failures = 0;

    // Model of the load-unit capture registers.
    logic [31:0] m_lu_data;
    logic [1:0]  m_lu_lo, m_lu_size;
    logic        m_lu_uns, m_lu_resp;

    always #5 clk = ~clk;

    msrv_32_dmem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .ms_riscv32_mp_clk_in        (clk),
        .ms_riscv32_mp_rst_in        (rst),
        .mem_valid_in                (mem_valid),
        .mem_is_store_in             (mem_is_store),
        .iadder_in                   (iadder),
        .rs2_in                      (rs2),
        .load_size_in                (load_size),
        .load_unsigned_in            (load_unsigned),
        .ahb_ready_in                (ahb_ready),
        .ahb_resp_in                 (ahb_resp),
        .ms_riscv32_mp_dmdata_in     (dmdata_in),
        .ms_riscv32_mp_dmaddr_out    (dmaddr),
        .ms_riscv32_mp_dmdata_out    (dmdata_out),
        .ms_riscv32_mp_dmwr_mask_out (wr_mask),
        .ms_riscv32_mp_dmwr_req_out  (wr_req),
        .ms_riscv32_mp_dmrd_req_out  (rd_req),
        .stall_out                   (stall),
        .done_out                    (done),
        .err_out                     (err),
        .misaligned_out              (misaligned),
        .lu_dmdata_out               (lu_dmdata),
        .lu_iadder_1_to_0_out        (lu_lo),
        .lu_load_size_out            (lu_size),
        .lu_load_unsigned_out        (lu_uns),
        .lu_resp_out                 (lu_resp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        checks++;
        assert (obs === expd) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expd);
        end
    endtask

    function automatic bit model_misaligned(input logic [1:0] sz, input logic [31:0] addr);
`ifdef MSRV32_MISALIGN_DETECT_EN
        return (sz == 2'b01 && addr[0]) || (sz[1] && addr[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    // Store lanes described arithmetically: replicate by multiplication, shift a run of ones.
    function automatic logic [31:0] model_data(input logic [1:0] sz, input logic [31:0] d);
        if (sz[1])        return d;
        else if (sz[0])   return {16'h0, d[15:0]} * 32'h0001_0001;
        else              return {24'h0, d[7:0]} * 32'h0101_0101;
    endfunction

    function automatic logic [3:0] model_mask(input logic [1:0] sz, input logic [31:0] a);
        int lanes;
        int first;
        lanes = sz[1] ? 4 : (sz[0] ? 2 : 1);
        first = sz[1] ? 0 : (sz[0] ? 2 * int'(a[1]) : int'(a[1:0]));
        return 4'(((1 << lanes) - 1) << first);
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_stall"},  32'(stall),      32'h0);
        check({tag, "_rdreq"},  32'(rd_req),     32'h0);
        check({tag, "_wrreq"},  32'(wr_req),     32'h0);
        check({tag, "_done"},   32'(done),       32'h0);
        check({tag, "_err"},    32'(err),        32'h0);
        check({tag, "_addr"},   dmaddr,          32'h0);
        check({tag, "_wdata"},  dmdata_out,      32'h0);
        check({tag, "_mask"},   32'(wr_mask),    32'h0);
        check({tag, "_ludata"}, lu_dmdata,       32'h0);
        check({tag, "_luresp"}, 32'(lu_resp),    32'h0);
        check({tag, "_mis"},    32'(misaligned), 32'h0);
    endtask

    task automatic check_lu(input string tag);
        check({tag, "_ludata"}, lu_dmdata,     m_lu_data);
        check({tag, "_lulo"},   32'(lu_lo),    32'(m_lu_lo));
        check({tag, "_lusize"}, 32'(lu_size),  32'(m_lu_size));
        check({tag, "_luuns"},  32'(lu_uns),   32'(m_lu_uns));
        check({tag, "_luresp"}, 32'(lu_resp),  32'(m_lu_resp));
    endtask

    // One complete transaction. rdy_cyc = REQ cycle in which ready is raised (0 = never).
    task automatic access(input string tag, input logic st, input logic [31:0] addr,
                          input logic [31:0] d, input logic [1:0] sz, input logic uns,
                          input int rdy_cyc, input logic resp, input logic [31:0] rdata);
        bit mis;
        bit timed_out;
        int exit_cyc;
        logic exp_err;
        mis       = model_misaligned(sz, addr);
        timed_out = !mis && (rdy_cyc == 0 || rdy_cyc > TMO);
        exit_cyc  = mis ? 1 : (timed_out ? TMO : rdy_cyc);
        exp_err   = mis ? 1'b0 : (timed_out ? 1'b1 : resp);

        @(negedge clk);
        mem_valid = 1'b1; mem_is_store = st; iadder = addr; rs2 = d;
        load_size = sz; load_unsigned = uns; ahb_ready = 1'b0; ahb_resp = 1'b0;
        @(negedge clk);
        mem_valid = 1'b0;
        for (int c = 1; c <= exit_cyc; c++) begin
            check({tag, "_stall"}, 32'(stall),  32'h1);
            check({tag, "_done0"}, 32'(done),   32'h0);
            check({tag, "_rdreq"}, 32'(rd_req), 32'(!st && !mis));
            check({tag, "_wrreq"}, 32'(wr_req), 32'(st && !mis));
            check({tag, "_addr"},  dmaddr,      {addr[31:2], 2'b00});
            if (!mis) begin
                check({tag, "_mask"}, 32'(wr_mask), st ? 32'(model_mask(sz, addr)) : 32'h0);
                if (st) check({tag, "_wdata"}, dmdata_out, model_data(sz, d));
            end
            if (!mis && c == rdy_cyc) begin
                ahb_ready = 1'b1; ahb_resp = resp; dmdata_in = rdata;
            end
            @(negedge clk);
            ahb_ready = 1'b0; ahb_resp = 1'b0;
        end
        if (!st && !mis) begin
            m_lu_data = exp_err ? 32'h0 : rdata;
            m_lu_resp = exp_err;
            m_lu_lo   = addr[1:0];
            m_lu_size = sz;
            m_lu_uns  = uns;
        end
        check({tag, "_done"},     32'(done),       32'h1);
        check({tag, "_err"},      32'(err),        32'(exp_err));
        check({tag, "_mis"},      32'(misaligned), 32'(mis));
        check({tag, "_stall_end"},32'(stall),      32'h0);
        check({tag, "_rd_end"},   32'(rd_req),     32'h0);
        check({tag, "_wr_end"},   32'(wr_req),     32'h0);
        check_lu(tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        mem_valid = 1'b0; mem_is_store = 1'b0; iadder = '0; rs2 = '0;
        load_size = '0; load_unsigned = 1'b0; ahb_ready = 1'b0; ahb_resp = 1'b0;
        dmdata_in = '0;
        m_lu_data = '0; m_lu_lo = '0; m_lu_size = '0; m_lu_uns = 1'b0; m_lu_resp = 1'b0;

        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        // Byte store to the top lane, ready in the first REQ cycle.
        access("sb_1003", 1'b1, 32'h0000_1003, 32'h0000_00AB, 2'b00, 1'b0, 1, 1'b0, 32'h0);
        // Word load, ready in the third REQ cycle.
        access("lw_2000", 1'b0, 32'h0000_2000, 32'h0, 2'b10, 1'b0, 3, 1'b0, 32'hDEAD_BEEF);
        // Half load with a bus error: data forced to zero.
        access("lh_err", 1'b0, 32'h0000_2002, 32'h0, 2'b01, 1'b1, 1, 1'b1, 32'h1234_5678);
        // Ready never arrives: watchdog aborts after TMO REQ cycles.
        access("timeout", 1'b0, 32'h0000_4008, 32'h0, 2'b10, 1'b0, 0, 1'b0, 32'h0);
        // Ready arrives in the very last watchdog cycle: completes normally.
        access("rdy_last", 1'b0, 32'h0000_400C, 32'h0, 2'b10, 1'b0, TMO, 1'b0, 32'hCAFE_F00D);
        // Half store to the upper half.
        access("sh_upper", 1'b1, 32'h0000_5002, 32'h1234_BEEF, 2'b01, 1'b0, 2, 1'b0, 32'h0);

        // Back-to-back loads with mem_valid held across the done cycle.
        @(negedge clk);
        mem_valid = 1'b1; mem_is_store = 1'b0; iadder = 32'h0000_6004;
        load_size = 2'b10; load_unsigned = 1'b0;
        @(negedge clk);
        check("b2b_a_rdreq", 32'(rd_req), 32'h1);
        ahb_ready = 1'b1; ahb_resp = 1'b0; dmdata_in = 32'h1111_AAAA;
        @(negedge clk);
        check("b2b_a_done", 32'(done), 32'h1);
        check("b2b_a_data", lu_dmdata, 32'h1111_AAAA);
        iadder = 32'h0000_6101; load_size = 2'b00; load_unsigned = 1'b1; ahb_ready = 1'b0;
        @(negedge clk);
        check("b2b_b_stall", 32'(stall),  32'h1);
        check("b2b_b_rdreq", 32'(rd_req), 32'h1);
        check("b2b_b_addr",  dmaddr,      32'h0000_6100);
        check("b2b_b_done0", 32'(done),   32'h0);
        mem_valid = 1'b0;
        ahb_ready = 1'b1; dmdata_in = 32'h2222_BBBB;
        @(negedge clk);
        ahb_ready = 1'b0;
        m_lu_data = 32'h2222_BBBB; m_lu_resp = 1'b0; m_lu_lo = 2'b01;
        m_lu_size = 2'b00; m_lu_uns = 1'b1;
        check("b2b_b_done", 32'(done), 32'h1);
        check_lu("b2b_b");
        @(negedge clk);

        // Reset pulse in the middle of an open request.
        mem_valid = 1'b1; mem_is_store = 1'b0; iadder = 32'h0000_7000; load_size = 2'b10;
        @(negedge clk);
        mem_valid = 1'b0;
        @(negedge clk);
        check("midrst_stall_pre", 32'(stall), 32'h1);
        rst = 1'b1;
        #1;
        check_outputs_zero("midrst");
        m_lu_data = '0; m_lu_lo = '0; m_lu_size = '0; m_lu_uns = 1'b0; m_lu_resp = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_nodone", 32'(done), 32'h0);
        end

`ifdef MSRV32_MISALIGN_DETECT_EN
        // Misaligned word store: completes with no write request.
        access("sw_mis", 1'b1, 32'h0000_3001, 32'h5555_AAAA, 2'b10, 1'b0, 1, 1'b0, 32'h0);
`endif

        // Random traffic against the transaction model.
        for (int n = 0; n < 30; n++) begin
            logic        st, uns, resp;
            logic [31:0] a, d, rd;
            logic [1:0]  sz;
            int          rc;
            st   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            resp = ($urandom_range(0, 3) == 0);
            a    = $urandom;
            d    = $urandom;
            rd   = $urandom;
            sz   = 2'($urandom_range(0, 3));
            rc   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
            access("rand", st, a, d, sz, uns, rc, resp, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so a wedged run still terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench time limit");
    end

endmodule
